avalon_master_rr_scheduler: RTL and testbench

//  Shares one Avalon-MM master port between NUM_REQ requesters, each issuing a word transfer (read or write, base address, length).

---
 rtl/avalon_master_rr_scheduler_pkg.sv | 18 +
 rtl/rr_grant_picker.sv | 37 +++
 rtl/avalon_master_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_avalon_master_rr_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_master_rr_scheduler_pkg.sv
// ms_sched_pkg: shared types and constants for the Avalon-MM
// round-robin master scheduler.
package ms_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // Index following idx, wrapping back to 0 after n-1
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// rr_grant_picker: first request at or after the round-robin pointer,
// wrapping modulo NUM_REQ; purely combinational.
module rr_grant_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any_req
);

    logic found;
    int   c;

    // Scan requesters starting at ptr and take the first one pending
    always_comb begin
        grant   = '0;
        index   = '0;
        any_req = |req;
        found   = 1'b0;
        c       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                index    = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/avalon_master_rr_scheduler.sv
// avalon_master_rr_scheduler: shares one Avalon-MM master port between
// NUM_REQ requesters, granting whole transfers in round-robin order.
module avalon_master_rr_scheduler
    import ms_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*LEN_W-1:0]  req_length,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        data_ack,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [ADDR_W-1:0]         master_address,
    output logic                      master_read,
    output logic                      master_write,
    output logic [DATA_W-1:0]         master_writedata,
    input  logic [DATA_W-1:0]         master_readdata,
    input  logic                      master_waitrequest
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   remaining;
    logic               read_q;
    logic               write_q;

    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_req;

    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic               sel_write;
    logic [IDX_W-1:0]   next_ptr;
    logic [DATA_W-1:0]  own_wdata;
    logic [NUM_REQ-1:0] owner_oh;
    logic               accept;
    logic               last_word;

    rr_grant_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (grant_oh),
        .index   (grant_idx),
        .any_req (any_req)
    );

    // Transfer fields of the requester that would be granted now
    always_comb begin
        sel_addr  = req_address[int'(grant_idx)*ADDR_W +: ADDR_W];
        sel_len   = req_length[int'(grant_idx)*LEN_W +: LEN_W];
        sel_write = |(req_write & grant_oh);
        next_ptr  = IDX_W'(rr_next(int'(grant_idx), NUM_REQ));
    end

    // Owner decode, word acceptance and live write-data selection
    always_comb begin
        own_wdata = req_writedata[int'(owner)*DATA_W +: DATA_W];
        owner_oh  = NUM_REQ'(1) << owner;
        accept    = (read_q | write_q) & ~master_waitrequest;
        last_word = (remaining == LEN_W'(1));
    end

    // Grant, latch transfer fields, step words, then one completion beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            addr      <= '0;
            remaining <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= grant_idx;
                        addr      <= sel_addr;
                        remaining <= sel_len;
                        ptr       <= next_ptr;
                        if (sel_len != '0) begin
                            read_q  <= ~sel_write;
                            write_q <= sel_write;
                            state   <= XFER;
                        end else begin
                            state   <= FIN;
                        end
                    end
                end
                XFER: begin
                    if (accept) begin
                        addr      <= addr + ADDR_W'(WORD_BYTES);
                        remaining <= remaining - LEN_W'(1);
                        if (last_word) begin
                            read_q  <= 1'b0;
                            write_q <= 1'b0;
                            state   <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus drive and per-requester handshakes
    always_comb begin
        master_address   = addr;
        master_read      = read_q;
        master_write     = write_q;
        master_writedata = write_q ? own_wdata : '0;
        data_ack         = accept ? owner_oh : '0;
        rd_data          = (accept & read_q) ? master_readdata : '0;
        done             = (state == FIN) ? owner_oh : '0;
        busy             = (state != IDLE);
    end

endmodule

// File: tb/tb_avalon_master_rr_scheduler.sv
// Bench for avalon_master_rr_scheduler: transaction-level reference
// model compared every cycle, directed scenarios, then random traffic.
module tb_avalon_master_rr_scheduler;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_address = '0;
    logic [N*LW-1:0]   req_length = '0;
    logic [N*DW-1:0]   req_writedata = '0;
    logic [N-1:0]      data_ack;
    logic [DW-1:0]     rd_data;
    logic [N-1:0]      done;
    logic              busy;
    logic [AW-1:0]     master_address;
    logic              master_read;
    logic              master_write;
    logic [DW-1:0]     master_writedata;
    logic [DW-1:0]     master_readdata = '0;
    logic              master_waitrequest = 1'b0;

    avalon_master_rr_scheduler #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .LEN_W   (LW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_write          (req_write),
        .req_address        (req_address),
        .req_length         (req_length),
        .req_writedata      (req_writedata),
        .data_ack           (data_ack),
        .rd_data            (rd_data),
        .done               (done),
        .busy               (busy),
        .master_address     (master_address),
        .master_read        (master_read),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_readdata    (master_readdata),
        .master_waitrequest (master_waitrequest)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wmode = 0;
    int stall_cnt = 0;
    logic [N-1:0] seen_done = '0;

    logic [AW-1:0] acc_addr[$];
    int            acc_cyc[$];
    int            done_who[$];
    int            done_cyc[$];
    int            strobe_cnt = 0;

    // reference model: current owner (-1 none), completion flag, pointer
    int            m_owner = -1;
    bit            m_fin = 0;
    bit            m_dir = 0;
    int            m_left = 0;
    int            m_ptr = 0;
    logic [AW-1:0] m_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // per-cycle compare against the model, event logging, model advance
    always @(negedge clk) begin
        bit           xfer;
        bit           acc;
        bit           found;
        int           g;
        int           c;
        logic [N-1:0] e_ack;
        logic [N-1:0] e_done;
        logic [DW-1:0] e_rd;
        if (!reset_n) begin
            m_owner = -1; m_fin = 0; m_ptr = 0; m_left = 0; m_addr = '0;
        end
        xfer = (m_owner >= 0) && !m_fin;
        acc = xfer && !master_waitrequest;
        e_ack = '0; e_done = '0; e_rd = '0;
        if (acc) e_ack[m_owner] = 1'b1;
        if (m_owner >= 0 && m_fin) e_done[m_owner] = 1'b1;
        if (acc && !m_dir) e_rd = master_readdata;
        chk("busy", busy, m_owner >= 0);
        chk("read", master_read, xfer && !m_dir);
        chk("write", master_write, xfer && m_dir);
        chk("data_ack", data_ack, e_ack);
        chk("done", done, e_done);
        if (xfer) chk("address", master_address, m_addr);
        if (xfer && m_dir)
            chk("writedata", master_writedata, req_writedata[m_owner*DW +: DW]);
        if ((acc && !m_dir) || !reset_n) chk("rd_data", rd_data, e_rd);
        if (!reset_n) begin
            chk("rst_address", master_address, 0);
            chk("rst_wdata", master_writedata, 0);
        end
        if (master_read || master_write) begin
            strobe_cnt++;
            if (!master_waitrequest) begin
                acc_addr.push_back(master_address);
                acc_cyc.push_back(cyc);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (done[k]) begin
                done_who.push_back(k);
                done_cyc.push_back(cyc);
            end
        end
        seen_done = done;
        if (reset_n) begin
            if (m_owner < 0) begin
                if (|req_valid) begin
                    found = 0; g = 0;
                    for (int k = 0; k < N; k++) begin
                        c = (m_ptr + k) % N;
                        if (!found && req_valid[c]) begin
                            found = 1; g = c;
                        end
                    end
                    m_owner = g;
                    m_addr = req_address[g*AW +: AW];
                    m_left = int'(req_length[g*LW +: LW]);
                    m_dir = req_write[g];
                    m_ptr = (g + 1) % N;
                    m_fin = (m_left == 0);
                end
            end else if (m_fin) begin
                m_owner = -1;
                m_fin = 0;
            end else if (acc) begin
                m_addr = m_addr + 4;
                m_left = m_left - 1;
                if (m_left == 0) m_fin = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        master_readdata = $urandom;
        req_writedata = {$urandom, $urandom};
        if (wmode == 1) begin
            if ((master_read || master_write) && stall_cnt < 2) begin
                master_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                master_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end else if (wmode == 2) begin
            master_waitrequest = ($urandom % 4 == 0);
        end else begin
            master_waitrequest = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input bit w, input logic [AW-1:0] a,
                           input int len);
        req_write[i] = w;
        req_address[i*AW +: AW] = a;
        req_length[i*LW +: LW] = LW'(len);
        req_valid[i] = 1'b1;
    endtask

    task automatic clear_log();
        acc_addr.delete(); acc_cyc.delete();
        done_who.delete(); done_cyc.delete();
        strobe_cnt = 0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int k;
        k = 0;
        while (!seen_done[i] && k < budget) begin
            tick();
            k++;
        end
        chk($sformatf("done_seen_%0d", i), seen_done[i], 1);
        req_valid[i] = 1'b0;
    endtask

    task automatic rand_fields(input int i);
        int r;
        r = $urandom % 40;
        req_write[i] = $urandom % 2;
        req_address[i*AW +: AW] = $urandom & 32'hFFFF_FFFC;
        req_length[i*LW +: LW] = (r == 0) ? 8'd255 : LW'(r % 7);
    endtask

    initial begin
        int c0;
        int k;
        int cnt[N];

        // reset
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("r_busy", busy, 0);
        chk("r_strobes", {master_read, master_write}, 0);
        chk("r_handshake", {data_ack, done}, 0);
        chk("r_addr", master_address, 0);
        chk("r_rd_data", rd_data, 0);

        // single write, no stalls
        clear_log();
        c0 = cyc;
        set_req(0, 1, 32'h1000, 3);
        wait_done(0, 50);
        chk("w_n", acc_addr.size(), 3);
        if (acc_addr.size() == 3) begin
            chk("w_a0", acc_addr[0], 32'h1000);
            chk("w_a1", acc_addr[1], 32'h1004);
            chk("w_a2", acc_addr[2], 32'h1008);
            chk("w_c0", acc_cyc[0], c0 + 1);
            chk("w_c2", acc_cyc[2], c0 + 3);
        end
        chk("w_dn", done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("w_dc", done_cyc[0], c0 + 4);

        // read with two stall cycles per word
        tick();
        wmode = 1;
        clear_log();
        c0 = cyc;
        set_req(1, 0, 32'h0000_0248, 2);
        wait_done(1, 50);
        chk("s_strobes", strobe_cnt, 6);
        chk("s_n", acc_addr.size(), 2);
        if (acc_addr.size() == 2) begin
            chk("s_a0", acc_addr[0], 32'h248);
            chk("s_a1", acc_addr[1], 32'h24C);
            chk("s_c0", acc_cyc[0], c0 + 3);
            chk("s_c1", acc_cyc[1], c0 + 6);
        end
        if (done_cyc.size() == 1) chk("s_dc", done_cyc[0], c0 + 7);
        chk("s_who", done_who.size() == 1 && done_who[0] == 1, 1);
        wmode = 0;

        // contention: both length 1, each re-asserts once after done
        tick();
        clear_log();
        set_req(0, 1, 32'h100, 1);
        set_req(1, 0, 32'h200, 1);
        cnt[0] = 2; cnt[1] = 2;
        k = 0;
        while ((cnt[0] > 0 || cnt[1] > 0) && k < 200) begin
            tick();
            k++;
            for (int i = 0; i < N; i++) begin
                if (seen_done[i]) begin
                    req_valid[i] = 1'b0;
                    cnt[i]--;
                end else if (!req_valid[i] && cnt[i] > 0) begin
                    req_valid[i] = 1'b1;
                end
            end
        end
        chk("c_budget", k < 200, 1);
        chk("c_n", done_who.size(), 4);
        if (done_who.size() == 4) begin
            chk("c_g0", done_who[0], 0);
            chk("c_g1", done_who[1], 1);
            chk("c_g2", done_who[2], 0);
            chk("c_g3", done_who[3], 1);
        end
        chk("c_words", acc_addr.size(), 4);

        // zero length, then address wrap
        tick();
        clear_log();
        c0 = cyc;
        set_req(0, 1, 32'h3000, 0);
        wait_done(0, 20);
        chk("z_strobes", strobe_cnt, 0);
        if (done_cyc.size() == 1) chk("z_dc", done_cyc[0], c0 + 1);
        tick();
        clear_log();
        set_req(1, 0, 32'hFFFF_FFFC, 2);
        wait_done(1, 20);
        chk("x_n", acc_addr.size(), 2);
        if (acc_addr.size() == 2) begin
            chk("x_a0", acc_addr[0], 32'hFFFF_FFFC);
            chk("x_a1", acc_addr[1], 32'h0000_0000);
        end

        // reset during word 2 of a 4-word write
        tick();
        clear_log();
        set_req(0, 1, 32'h2000, 4);
        tick(); tick();
        chk("a_pre", master_write, 1);
        reset_n = 1'b0;
        #1;
        chk("a_write", master_write, 0);
        chk("a_busy", busy, 0);
        req_valid = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("a_nodone", done_who.size(), 0);
        clear_log();
        set_req(1, 1, 32'h40, 1);
        wait_done(1, 20);
        chk("a_n", acc_addr.size(), 1);
        if (acc_addr.size() == 1) chk("a_addr", acc_addr[0], 32'h40);

        // random traffic with random stalls
        wmode = 2;
        for (int it = 0; it < 4000; it++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (seen_done[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom % 3 == 0) begin
                    rand_fields(i);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom % 4 == 0) begin
                    rand_fields(i);
                end
            end
        end
        k = 0;
        while ((req_valid != '0 || busy) && k < 3000) begin
            tick();
            k++;
            for (int i = 0; i < N; i++) begin
                if (seen_done[i]) req_valid[i] = 1'b0;
            end
        end
        chk("drain", k < 3000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
